// File: rtl/tdc_pkg.sv
// Shared types and widths for the TDC measurement controller.
// Holds the FSM state encoding and the timeout-load helper.
package tdc_pkg;

    localparam int TOF_W  = 13;
    localparam int SHOT_W = 4;
    localparam int SUM_W  = 17;
    localparam int HIT_W  = 5;
    localparam int TMO_W  = 8;
    localparam int CNT_W  = TMO_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_FIRE,
        S_WAIT,
        S_NEXT,
        S_DONE
    } state_e;

    // A programmed window of 0 stands for the full 256-cycle window.
    function automatic logic [CNT_W-1:0] tmo_load(input logic [TMO_W-1:0] t);
        if (t == '0) begin
            return {1'b1, {TMO_W{1'b0}}};
        end
        return {1'b0, t};
    endfunction

endpackage

// File: rtl/tdc_meas_ctrl_if.sv
// Config, TDC and result signals of the measurement controller.
// master = controller side, slave = TDC/host side.
interface tdc_meas_ctrl_if;
    import tdc_pkg::*;

    logic             cfg_en;
    logic [SHOT_W-1:0] cfg_shots;
    logic [TMO_W-1:0]  cfg_timeout;
    logic             tdc_rst_n;
    logic             tdc_start;
    logic             tdc_valid;
    logic [TOF_W-1:0]  tdc_tof;
    logic             res_valid;
    logic             res_ready;
    logic [SUM_W-1:0]  res_sum;
    logic [HIT_W-1:0]  res_hits;
    logic             busy;

    modport master (
        input  cfg_en, cfg_shots, cfg_timeout,
        input  tdc_valid, tdc_tof, res_ready,
        output tdc_rst_n, tdc_start,
        output res_valid, res_sum, res_hits, busy
    );

    modport slave (
        output cfg_en, cfg_shots, cfg_timeout,
        output tdc_valid, tdc_tof, res_ready,
        input  tdc_rst_n, tdc_start,
        input  res_valid, res_sum, res_hits, busy
    );

endinterface

// File: rtl/tdc_sync2.sv
// Two-flop synchronizer bringing the TDC valid flag into sync_clk.
// Both flops clear on reset.
module tdc_sync2 (
    input  logic sync_clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic s1_q;
    logic s2_q;

    // Shift the asynchronous flag through two flops.
    always_ff @(posedge sync_clk or negedge rst) begin
        if (!rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/tdc_meas_ctrl.sv
// Multi-shot TDC measurement controller: re-arm, fire, wait for
// a return or timeout, accumulate tof, then present the result.
module tdc_meas_ctrl
    import tdc_pkg::*;
(
    input  logic       sync_clk,
    input  logic       rst,
    tdc_meas_ctrl_if.master bus
);

    state_e            state_q;
    logic              arm_q;
    logic [CNT_W-1:0]  tmo_q;
    logic [HIT_W-1:0]  shot_q;
    logic [SHOT_W-1:0] shots_q;
    logic [TMO_W-1:0]  tmo_cfg_q;
    logic [SUM_W-1:0]  sum_q;
    logic [HIT_W-1:0]  hits_q;
    logic              tdc_rst_n_q;
    logic              tdc_start_q;
    logic              res_valid_q;
    logic              busy_q;
    logic              hit;
    logic [SUM_W-1:0]  sum_d;

    tdc_sync2 u_sync (
        .sync_clk (sync_clk),
        .rst      (rst),
        .d_i      (bus.tdc_valid),
        .q_o      (hit)
    );

    assign sum_d = sum_q + {{(SUM_W-TOF_W){1'b0}}, bus.tdc_tof};

    // Measurement sequencer with registered outputs.
    always_ff @(posedge sync_clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            arm_q       <= 1'b0;
            tmo_q       <= '0;
            shot_q      <= '0;
            shots_q     <= '0;
            tmo_cfg_q   <= '0;
            sum_q       <= '0;
            hits_q      <= '0;
            tdc_rst_n_q <= 1'b1;
            tdc_start_q <= 1'b0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.cfg_en) begin
                        shots_q     <= bus.cfg_shots;
                        tmo_cfg_q   <= bus.cfg_timeout;
                        sum_q       <= '0;
                        hits_q      <= '0;
                        shot_q      <= '0;
                        arm_q       <= 1'b0;
                        tdc_rst_n_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= S_ARM;
                    end
                end
                S_ARM: begin
                    if (arm_q) begin
                        arm_q       <= 1'b0;
                        tdc_rst_n_q <= 1'b1;
                        tdc_start_q <= 1'b1;
                        state_q     <= S_FIRE;
                    end else begin
                        arm_q <= 1'b1;
                    end
                end
                S_FIRE: begin
                    tmo_q       <= tmo_load(tmo_cfg_q);
                    tdc_start_q <= 1'b0;
                    state_q     <= S_WAIT;
                end
                S_WAIT: begin
                    if (hit) begin
                        sum_q   <= sum_d;
                        hits_q  <= hits_q + 5'd1;
                        state_q <= S_NEXT;
                    end else begin
                        tmo_q <= tmo_q - 9'd1;
                        if (tmo_q == 9'd1) begin
                            state_q <= S_NEXT;
                        end
                    end
                end
                S_NEXT: begin
                    shot_q <= shot_q + 5'd1;
                    if (shot_q == {1'b0, shots_q}) begin
                        res_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        tdc_rst_n_q <= 1'b0;
                        state_q     <= S_ARM;
                    end
                end
                S_DONE: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.tdc_rst_n = tdc_rst_n_q;
    assign bus.tdc_start = tdc_start_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_sum   = sum_q;
    assign bus.res_hits  = hits_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_tdc_meas_ctrl.sv
// Bench for tdc_meas_ctrl: a TDC model answers each start pulse,
// and a per-shot window model predicts sum, hits and wait lengths.
module tb_tdc_meas_ctrl;

    logic clk;
    logic rst;

    tdc_meas_ctrl_if bus ();

    tdc_meas_ctrl dut (
        .sync_clk (clk),
        .rst      (rst),
        .bus      (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total  = 0;
    int passed = 0;
    int failed = 0;

    // Planned behaviour of the TDC for each shot of a measurement.
    int m_hit [16];
    int m_dly [16];
    int m_tof [16];
    int m_wait[16];
    int m_idx  = -1;
    int starts = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Window model: the window opens the cycle after start and lasts
    // teff cycles; a return d cycles after start is seen d+2 cycles
    // after start through the synchronizer.
    task automatic plan(input int shots, input int tmo,
                        output int esum, output int ehits);
        int teff;
        teff  = (tmo == 0) ? 256 : tmo;
        esum  = 0;
        ehits = 0;
        for (int i = 0; i <= shots; i++) begin
            if (m_hit[i] != 0 && m_dly[i] <= teff - 2) begin
                esum  += m_tof[i];
                ehits += 1;
                m_wait[i] = m_dly[i] + 2;
            end else begin
                m_wait[i] = teff;
            end
        end
    endtask

    // TDC model and shot-timing monitor, sampled on the falling edge.
    initial begin
        int  lowcnt;
        int  wcnt;
        int  cnt;
        bit  timing;
        bit  pend;
        lowcnt = 0;
        wcnt   = 0;
        cnt    = 0;
        timing = 0;
        pend   = 0;
        bus.tdc_valid = 1'b0;
        bus.tdc_tof   = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                bus.tdc_valid = 1'b0;
                pend   = 0;
                timing = 0;
                lowcnt = 0;
            end else begin
                if (timing && (!bus.tdc_rst_n || bus.res_valid)) begin
                    timing = 0;
                    if (m_idx >= 0 && m_idx < 16)
                        check("wait_len", wcnt - 1, m_wait[m_idx]);
                end else if (timing) begin
                    wcnt++;
                end
                if (!bus.tdc_rst_n) begin
                    bus.tdc_valid = 1'b0;
                    pend = 0;
                    lowcnt++;
                end else if (bus.tdc_start) begin
                    check("arm_len", lowcnt, 2);
                    lowcnt = 0;
                    m_idx++;
                    starts++;
                    timing = 1;
                    wcnt   = 0;
                    if (m_idx >= 0 && m_idx < 16 && m_hit[m_idx] != 0) begin
                        if (m_dly[m_idx] == 0) begin
                            bus.tdc_tof   = 13'(m_tof[m_idx]);
                            bus.tdc_valid = 1'b1;
                        end else begin
                            pend = 1;
                            cnt  = m_dly[m_idx];
                        end
                    end
                end else begin
                    lowcnt = 0;
                    if (pend) begin
                        cnt--;
                        if (cnt == 0) begin
                            pend = 0;
                            bus.tdc_tof   = 13'(m_tof[m_idx]);
                            bus.tdc_valid = 1'b1;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic start_meas(input int shots, input int tmo);
        int n;
        @(negedge clk);
        m_idx = -1;
        starts = 0;
        bus.cfg_shots   = 4'(shots);
        bus.cfg_timeout = 8'(tmo);
        bus.cfg_en      = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.busy && n < 4);
        bus.cfg_en = 1'b0;
        check("busy_rise", bus.busy, 1);
    endtask

    task automatic run_meas(input int shots, input int tmo,
                            input int bp, input bit chg);
        int esum;
        int ehits;
        int n;
        logic [16:0] s0;
        logic [4:0]  h0;
        plan(shots, tmo, esum, ehits);
        start_meas(shots, tmo);
        if (chg) begin
            bus.cfg_shots   = 4'($urandom_range(0, 15));
            bus.cfg_timeout = 8'($urandom_range(1, 255));
        end
        n = 0;
        while (!bus.res_valid && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check("res_valid", bus.res_valid, 1);
        check("res_sum", bus.res_sum, esum);
        check("res_hits", bus.res_hits, ehits);
        check("start_cnt", starts, shots + 1);
        s0 = bus.res_sum;
        h0 = bus.res_hits;
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            check("bp_valid", bus.res_valid, 1);
            check("bp_sum", bus.res_sum, esum);
            check("bp_hits", bus.res_hits, ehits);
            check("bp_starts", starts, shots + 1);
        end
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        check("post_valid", bus.res_valid, 0);
        check("post_busy", bus.busy, 0);
        check("post_sum", bus.res_sum, s0);
        check("post_hits", bus.res_hits, h0);
        repeat (3) @(negedge clk);
        check("idle_starts", starts, shots + 1);
    endtask

    task automatic fill(input int shots, input int hit,
                        input int dmax, input int tof);
        for (int i = 0; i < 16; i++) begin
            m_hit[i] = (i <= shots) ? hit : 0;
            m_dly[i] = $urandom_range(0, dmax);
            m_tof[i] = (tof < 0) ? $urandom_range(0, 8191) : tof;
        end
    endtask

    initial begin
        int esum;
        int ehits;
        int n;
        rst           = 1'b0;
        bus.cfg_en    = 1'b0;
        bus.cfg_shots = '0;
        bus.cfg_timeout = '0;
        bus.res_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            m_hit[i] = 0; m_dly[i] = 0; m_tof[i] = 0; m_wait[i] = 0;
        end
        repeat (3) @(negedge clk);
        check("rst_tdc_rst_n", bus.tdc_rst_n, 1);
        check("rst_start", bus.tdc_start, 0);
        check("rst_valid", bus.res_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_sum", bus.res_sum, 0);
        check("rst_hits", bus.res_hits, 0);
        #2 rst = 1'b1;

        // Single shot, return 6 cycles after start.
        fill(0, 1, 0, 100);
        m_dly[0] = 6;
        run_meas(0, 20, 0, 0);

        // Four shots with tof 10..40.
        fill(3, 1, 18, 0);
        for (int i = 0; i < 4; i++) m_tof[i] = 10 * (i + 1);
        run_meas(3, 20, 1, 0);

        // No return, 5-cycle window.
        fill(1, 0, 0, 0);
        run_meas(1, 5, 0, 0);

        // Maximum load, 256-cycle window.
        fill(15, 1, 10, 8191);
        run_meas(15, 0, 0, 0);

        // 256-cycle window without returns.
        fill(1, 0, 0, 0);
        run_meas(1, 0, 0, 0);

        // Backpressure with config changes mid-run.
        fill(5, 1, 14, -1);
        run_meas(5, 12, 10, 1);

        // Return at the last cycle of the window, then one cycle late.
        fill(1, 1, 0, 0);
        m_dly[0] = 6; m_tof[0] = 500;
        m_dly[1] = 7; m_tof[1] = 600;
        plan(1, 8, esum, ehits);
        check("edge_model_hits", ehits, 1);
        run_meas(1, 8, 0, 0);

        // Latest return in the 256-cycle window.
        fill(0, 1, 0, 77);
        m_dly[0] = 254;
        run_meas(0, 0, 0, 0);

        // Randomized measurements.
        for (int k = 0; k < 8; k++) begin
            int sh;
            int tm;
            sh = $urandom_range(0, 15);
            tm = $urandom_range(3, 40);
            fill(sh, 1, tm + 3, -1);
            for (int i = 0; i <= sh; i++)
                m_hit[i] = ($urandom_range(0, 3) != 0) ? 1 : 0;
            run_meas(sh, tm, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of a wait window.
        fill(2, 0, 0, 0);
        plan(2, 50, esum, ehits);
        start_meas(2, 50);
        n = 0;
        while (starts == 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("pre_rst_start", starts, 1);
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_n", bus.tdc_rst_n, 1);
        check("mid_start", bus.tdc_start, 0);
        check("mid_valid", bus.res_valid, 0);
        check("mid_busy", bus.busy, 0);
        check("mid_sum", bus.res_sum, 0);
        check("mid_hits", bus.res_hits, 0);
        @(negedge clk);
        #2 rst = 1'b1;
        repeat (6) @(negedge clk);
        check("rst_idle_busy", bus.busy, 0);
        check("rst_idle_starts", starts, 1);

        // Normal operation after reset.
        fill(2, 1, 8, -1);
        run_meas(2, 10, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
